// File: rtl/skl_mw_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : skl_mw_add_seq
// Description : Multi-word add/subtract sequencer. Wide operands pass through
//               a single 32-bit Kogge-Stone adder, one slice per clock, least
//               significant slice first. The carry is registered between
//               slices. Valid/ready handshakes on both the request and the
//               result side.
// Ports       : clk          rising-edge clock
//               rst_n        asynchronous active-low reset
//               i_in_valid   request valid
//               o_in_ready   request accepted (high only when idle)
//               i_x1, i_x2   operands A and B, N = 32*WORDS bits each
//               i_cin        carry-in for add (ignored for subtract)
//               i_sub        1: x1 - x2, 0: x1 + x2 + cin
//               o_out_valid  result valid
//               i_out_ready  consumer accepts result
//               o_s          N-bit result, stable while o_out_valid is high
//               o_cout       carry out of bit N-1 (subtract: 1 = no borrow)
//               o_ovf        signed overflow of the N-bit operation
//               o_busy       operation in progress or result pending
// Revision    : 1.0 - initial release
// ============================================================================
module skl_mw_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [32*WORDS-1:0]   i_x1,
    input  logic [32*WORDS-1:0]   i_x2,
    input  logic                  i_cin,
    input  logic                  i_sub,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [32*WORDS-1:0]   o_s,
    output logic                  o_cout,
    output logic                  o_ovf,
    output logic                  o_busy
);

    localparam int                c_N    = 32 * WORDS;
    localparam int                c_IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [c_N-1:0]     r_a;
    logic [c_N-1:0]     r_b;        // already inverted for subtract
    logic [c_N-1:0]     r_sum;
    logic               r_carry;
    logic [c_IDXW-1:0]  r_idx;
    logic               r_cout;
    logic               r_ovf;

    logic [31:0]        w_x1;
    logic [31:0]        w_x2;
    logic [31:0]        w_sum;
    logic               w_co;
    logic               w_accept;
    logic               w_last;

    // 32-bit Kogge-Stone adder: five prefix levels over (generate, propagate),
    // carry-in folded in after the prefix tree.
    function automatic logic [32:0] f_ks_add(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        ci);
        logic [31:0] g;
        logic [31:0] p;
        logic [31:0] gn;
        logic [31:0] pn;
        logic [31:0] h;
        logic [31:0] c;
        g = a & b;
        h = a ^ b;
        p = h;
        for (int lvl = 0; lvl < 5; lvl++) begin
            gn = g;
            pn = p;
            for (int i = (1 << lvl); i < 32; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
                pn[i] = p[i] & p[i - (1 << lvl)];
            end
            g = gn;
            p = pn;
        end
        // Carry into bit i is the group (i-1:0) generate, or its propagate with cin.
        c = {g[30:0] | (p[30:0] & {31{ci}}), ci};
        return {g[31] | (p[31] & ci), h ^ c};
    endfunction

    assign w_x1 = r_a[{r_idx, 5'b00000} +: 32];
    assign w_x2 = r_b[{r_idx, 5'b00000} +: 32];
    assign {w_co, w_sum} = f_ks_add(w_x1, w_x2, r_carry);

    assign w_accept = (r_state == S_IDLE) && i_in_valid;
    assign w_last   = (r_idx == c_LAST);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_busy      = 1'b1;
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= i_x1;
            // Subtract is x1 + ~x2 + 1: invert B once here, seed carry with 1.
            r_b     <= i_sub ? ~i_x2 : i_x2;
            r_carry <= i_sub | i_cin;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (r_state == S_RUN) begin
            r_sum[{r_idx, 5'b00000} +: 32] <= w_sum;
            r_carry                        <= w_co;
            if (w_last) begin
                r_cout <= w_co;
                r_ovf  <= (r_a[c_N-1] == r_b[c_N-1]) && (w_sum[31] != r_a[c_N-1]);
            end else begin
                // Index parks on the last slice instead of wrapping.
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign o_s    = r_sum;
    assign o_cout = r_cout;
    assign o_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_skl_mw_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_skl_mw_add_seq
// Description : Self-checking bench for skl_mw_add_seq (WORDS = 4). Directed
//               vector table, hand-written backpressure and reset sequences,
//               and randomized operations against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skl_mw_add_seq;

    localparam int c_WORDS = 4;
    localparam int c_N     = 32 * c_WORDS;

    logic             clk;
    logic             rst_n;
    logic             r_in_valid;
    logic             w_in_ready;
    logic [c_N-1:0]   r_x1;
    logic [c_N-1:0]   r_x2;
    logic             r_cin;
    logic             r_sub;
    logic             w_out_valid;
    logic             r_out_ready;
    logic [c_N-1:0]   w_s;
    logic             w_cout;
    logic             w_ovf;
    logic             w_busy;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string          nm;
        logic [c_N-1:0] x1;
        logic [c_N-1:0] x2;
        logic           cin;
        logic           sub;
        logic [c_N-1:0] s;
        logic           cout;
        logic           ovf;
    } vec_t;

    vec_t vecs[$];

    skl_mw_add_seq #(.WORDS(c_WORDS)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (r_in_valid),
        .o_in_ready  (w_in_ready),
        .i_x1        (r_x1),
        .i_x2        (r_x2),
        .i_cin       (r_cin),
        .i_sub       (r_sub),
        .o_out_valid (w_out_valid),
        .i_out_ready (r_out_ready),
        .o_s         (w_s),
        .o_cout      (w_cout),
        .o_ovf       (w_ovf),
        .o_busy      (w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [c_N-1:0] act, input logic [c_N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed overflow from an extended-width sum.
    task automatic model(input logic [c_N-1:0] a, input logic [c_N-1:0] b,
                         input logic ci, input logic su,
                         output logic [c_N-1:0] s, output logic co, output logic ov);
        logic [c_N:0]   u;
        logic [c_N+1:0] t;
        if (su) begin
            u  = {1'b0, a} - {1'b0, b};
            co = (a >= b);
            t  = {{2{a[c_N-1]}}, a} - {{2{b[c_N-1]}}, b};
        end else begin
            u  = {1'b0, a} + {1'b0, b} + (c_N+1)'(ci);
            co = u[c_N];
            t  = {{2{a[c_N-1]}}, a} + {{2{b[c_N-1]}}, b} + (c_N+2)'(ci);
        end
        s  = u[c_N-1:0];
        ov = (t[c_N] != t[c_N-1]);
    endtask

    task automatic add_vec(input string nm, input logic [c_N-1:0] a, input logic [c_N-1:0] b,
                           input logic ci, input logic su, input logic [c_N-1:0] s,
                           input logic co, input logic ov);
        vec_t v;
        v.nm = nm; v.x1 = a; v.x2 = b; v.cin = ci; v.sub = su;
        v.s = s; v.cout = co; v.ovf = ov;
        vecs.push_back(v);
    endtask

    function automatic logic [c_N-1:0] rnd_wide();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issue one operation, check latency and result, then retire it.
    // Called and returns at #1 after a rising edge.
    task automatic run_op(input string nm, input logic [c_N-1:0] a, input logic [c_N-1:0] b,
                          input logic ci, input logic su, input logic [c_N-1:0] es,
                          input logic eco, input logic eov);
        int n;
        int lat;
        bit seen;
        n = 0;
        while (!w_in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, " in_ready"}, c_N'(w_in_ready), c_N'(1));
        r_in_valid = 1'b1; r_x1 = a; r_x2 = b; r_cin = ci; r_sub = su;
        @(posedge clk); #1;
        r_in_valid = 1'b0; r_x1 = rnd_wide(); r_x2 = rnd_wide();
        r_cin = 1'($urandom()); r_sub = 1'($urandom());
        lat = 0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (w_out_valid) seen = 1'b1;
            else r_out_ready = 1'($urandom());
        end
        chk({nm, " latency"}, c_N'(lat), c_N'(c_WORDS));
        chk({nm, " s"},    w_s, es);
        chk({nm, " cout"}, c_N'(w_cout), c_N'(eco));
        chk({nm, " ovf"},  c_N'(w_ovf), c_N'(eov));
        r_out_ready = 1'b1;
        @(posedge clk); #1;
        r_out_ready = 1'b0;
        chk({nm, " out_valid drop"}, c_N'(w_out_valid), c_N'(0));
    endtask

    initial begin
        logic [c_N-1:0] ones;
        logic [c_N-1:0] es;
        logic           eco;
        logic           eov;
        logic [c_N-1:0] a;
        logic [c_N-1:0] b;
        logic           ci;
        logic           su;
        int             n;

        ones = '1;
        add_vec("carry96", {32'h0, 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF}, 128'd1, 1'b0, 1'b0,
                128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0);
        add_vec("ripple", ones, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1, 1'b0);
        add_vec("sub5m7", 128'd5, 128'd7, 1'b0, 1'b1, ones - 128'd1, 1'b0, 1'b0);
        add_vec("sub7m5", 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1, 1'b0);
        add_vec("ovfadd", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, 127'd0}, 1'b0, 1'b1);
        add_vec("subcin", 128'd10, 128'd3, 1'b1, 1'b1, 128'd7, 1'b1, 1'b0);
        add_vec("ovfsub", {1'b1, 127'd0}, 128'd1, 1'b0, 1'b1, {1'b0, {127{1'b1}}}, 1'b1, 1'b1);
        add_vec("addcin", 128'd1, 128'd2, 1'b1, 1'b0, 128'd4, 1'b0, 1'b0);

        rst_n = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0;
        r_x1 = '0; r_x2 = '0; r_cin = 1'b0; r_sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        chk("reset in_ready",  c_N'(w_in_ready),  c_N'(1));
        chk("reset out_valid", c_N'(w_out_valid), c_N'(0));
        chk("reset busy",      c_N'(w_busy),      c_N'(0));
        chk("reset s",         w_s,               c_N'(0));
        chk("reset cout",      c_N'(w_cout),      c_N'(0));
        chk("reset ovf",       c_N'(w_ovf),       c_N'(0));

        // Directed vector table
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].nm, vecs[i].x1, vecs[i].x2, vecs[i].cin, vecs[i].sub,
                   vecs[i].s, vecs[i].cout, vecs[i].ovf);
        end

        // Backpressure: hold the result for 10 cycles while a second request knocks
        r_in_valid = 1'b1; r_x1 = {1'b0, {127{1'b1}}}; r_x2 = 128'd1; r_cin = 1'b0; r_sub = 1'b0;
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        n = 0;
        while (!w_out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("bp latency", c_N'(n), c_N'(c_WORDS));
        for (int k = 0; k < 10; k++) begin
            r_in_valid = 1'b1; r_x1 = rnd_wide(); r_x2 = rnd_wide(); r_out_ready = 1'b0;
            @(posedge clk); #1;
            chk("bp out_valid", c_N'(w_out_valid), c_N'(1));
            chk("bp in_ready",  c_N'(w_in_ready),  c_N'(0));
            chk("bp s",         w_s,               {1'b1, 127'd0});
            chk("bp cout",      c_N'(w_cout),      c_N'(0));
            chk("bp ovf",       c_N'(w_ovf),       c_N'(1));
        end
        r_in_valid = 1'b0; r_out_ready = 1'b1;
        @(posedge clk); #1;
        r_out_ready = 1'b0;
        chk("bp retire out_valid", c_N'(w_out_valid), c_N'(0));
        chk("bp retire in_ready",  c_N'(w_in_ready),  c_N'(1));
        @(posedge clk); #1;
        chk("bp nothing queued busy", c_N'(w_busy), c_N'(0));

        // Reset mid-RUN after slice 1
        r_in_valid = 1'b1; r_x1 = ones; r_x2 = ones; r_cin = 1'b1; r_sub = 1'b0;
        @(posedge clk); #1;
        r_in_valid = 1'b0;
        @(posedge clk); #1;
        chk("partial upper zero 1", c_N'(w_s[c_N-1:32]), c_N'(0));
        chk("partial slice0",       c_N'(w_s[31:0]),     c_N'(32'hFFFF_FFFF));
        @(posedge clk); #1;
        chk("partial upper zero 2", c_N'(w_s[c_N-1:64]), c_N'(0));
        rst_n = 1'b0;
        #1;
        chk("midrst in_ready",  c_N'(w_in_ready),  c_N'(1));
        chk("midrst out_valid", c_N'(w_out_valid), c_N'(0));
        chk("midrst busy",      c_N'(w_busy),      c_N'(0));
        chk("midrst s",         w_s,               c_N'(0));
        chk("midrst cout",      c_N'(w_cout),      c_N'(0));
        chk("midrst ovf",       c_N'(w_ovf),       c_N'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("after reset 3+4", 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0, 1'b0);

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 40; k++) begin
            a  = rnd_wide();
            b  = rnd_wide();
            ci = 1'($urandom());
            su = 1'($urandom());
            case (k % 5)
                0: b = a;
                1: a = ones;
                2: b[c_N-1] = a[c_N-1];
                default: ;
            endcase
            model(a, b, ci, su, es, eco, eov);
            run_op("random", a, b, ci, su, es, eco, eov);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skl_mw_add_seq.md
# skl_mw_add_seq

Multi-word add/subtract sequencer that streams wide operands through a single 32-bit parallel-prefix adder, one 32-bit slice per clock. Carry is registered between slices. It sits between a requester issuing wide arithmetic operations and the adder datapath, so designs can do 64/128/256-bit arithmetic without instantiating wide adders. It uses a valid/ready handshake on both the request and result sides.

## Interface
- WORDS, 4: number of 32-bit slices per operation; legal range 1..16; operand width N = 32*WORDS.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request; high only in IDLE.
- x1  input  N  operand A, captured on acceptance.
- x2  input  N  operand B, captured on acceptance.
- cin  input  1  carry-in for add; ignored when sub=1.
- sub  input  1  1 = compute x1 - x2 (two's complement); 0 = x1 + x2 + cin.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  N  result, held stable while out_valid=1.
- cout  output  1  carry out of bit N-1; for sub, 1 means no borrow.
- ovf  output  1  signed overflow of the N-bit operation.
- busy  output  1  high in RUN or DONE.

## Operation
- Internal registers: a_r[N], b_r[N] (b already inverted if sub), sum_r[N], carry_r, idx (clog2(WORDS) bits, minimum 1), state.
- Datapath: exactly one 32-bit adder; x1 = a_r slice idx, x2 = b_r slice idx, cin = carry_r; s -> sum_r slice idx; cout -> carry_r.
- FSM states:
  - IDLE: in_ready=1. On in_valid=1, capture x1 -> a_r, (sub ? ~x2 : x2) -> b_r, (sub ? 1 : cin) -> carry_r, idx=0, sum_r=0, then go to RUN. With in_valid=0, stay.
  - RUN: each cycle, write slice idx of sum_r, update carry_r, idx++. On the cycle with idx==WORDS-1, also set cout_r=adder cout, compute ovf, and go to DONE.
  - DONE: out_valid=1. On out_ready=1, go to IDLE. Otherwise hold all outputs unchanged.
- ovf = (a_r[N-1] == b_r[N-1]) && (final s[31] != a_r[N-1]), using the effective (possibly inverted) b.
- Outputs s/cout/ovf come directly from registers and are stable from DONE entry until the handshake completes.
- Upper slices of s not yet written during RUN read 0. s is only defined while out_valid=1.
- The request is not accepted in the cycle DONE is retired; in_ready rises the cycle after.
- Inputs x1/x2/cin/sub are don't-care except on the acceptance edge.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, in_ready=1, out_valid=0, busy=0, s=0, cout=0, ovf=0, idx=0, carry_r=0.
- Acceptance at edge E0 → out_valid is high after edge E_WORDS. Latency is WORDS cycles.
- With out_ready held high, the minimum issue interval is WORDS+2 cycles per operation (accept, WORDS RUN cycles, DONE).
- WORDS=1: RUN lasts one cycle, then DONE.
- Reset asserted mid-RUN or in DONE aborts the operation immediately. No result is produced and all outputs take their reset values.
- out_ready high while out_valid is low has no effect. in_valid high outside IDLE is ignored and not queued.
- idx never exceeds WORDS-1 and has no wrap-around visible on outputs.

## Test plan
- WORDS=4, add: x1=0x0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, x2=1, cin=0 → s=0x0000_0001_0000_0000_0000_0000_0000_0000, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
- Full carry ripple: x1=all-ones(128), x2=0, cin=1 → s=0, cout=1, ovf=0.
- Subtract: sub=1, x1=5, x2=7 → s=0xFFFF…FFFE (128-bit), cout=0 (borrow), ovf=0. Then sub=1, x1=7, x2=5 → s=2, cout=1.
- Signed overflow: x1=0x7FFF…FFFF, x2=1, add → s=0x8000…0000, ovf=1, cout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → s/cout/ovf/out_valid unchanged, in_ready=0, a second in_valid is ignored. After out_ready=1, in_ready is high one cycle later.
- Reset mid-RUN (after slice 1) → all outputs at reset values immediately. A new add of 3+4 then returns s=7 with correct latency.
